// File: rtl/sonic_tx_st_pkg.sv
// Shared types and default parameters for the SONIC TX streaming adapter.
// Contents:
//   DATA_W_DEF / DEPTH_DEF / RDY_LAT_DEF : default parameter values
//   tx_beat_t                            : one buffered beat at the default data width
//   frame_state_t                        : input framing checker states
package sonic_tx_st_pkg;

    localparam int unsigned DATA_W_DEF  = 128;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned RDY_LAT_DEF = 2;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  sop;
        logic                  eop;
        logic                  empty;
        logic                  err;
    } tx_beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_t;

endpackage

// File: rtl/sonic_tx_st_adapter_if.sv
// Bus bundle between the streaming application port and the hard-IP TX port.
// Modports:
//   master : the adapter (consumes in_*, tx_st_ready0; drives in_ready, tx_st_*, status)
//   slave  : the environment around the adapter
// Signals:
//   in_data/in_sop/in_eop/in_empty/in_valid, in_ready       : upstream beat handshake
//   tx_st_data0/sop0/eop0/empty0/err0/valid0, tx_st_ready0  : hard-IP Avalon-ST TX
//   fifo_level, frame_err                                   : status
interface sonic_tx_st_adapter_if
    import sonic_tx_st_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic              in_empty;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] tx_st_data0;
    logic              tx_st_sop0;
    logic              tx_st_eop0;
    logic              tx_st_empty0;
    logic              tx_st_err0;
    logic              tx_st_valid0;
    logic              tx_st_ready0;

    logic [LVL_W-1:0]  fifo_level;
    logic              frame_err;

    modport master (
        input  in_data, in_sop, in_eop, in_empty, in_valid, tx_st_ready0,
        output in_ready, tx_st_data0, tx_st_sop0, tx_st_eop0, tx_st_empty0,
               tx_st_err0, tx_st_valid0, fifo_level, frame_err
    );

    modport slave (
        output in_data, in_sop, in_eop, in_empty, in_valid, tx_st_ready0,
        input  in_ready, tx_st_data0, tx_st_sop0, tx_st_eop0, tx_st_empty0,
               tx_st_err0, tx_st_valid0, fifo_level, frame_err
    );

endinterface

// File: rtl/sonic_sync_fifo.sv
// Generic synchronous FIFO with show-ahead head (rdata_o is the oldest entry).
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   push_i, wdata_i   : write request and data (ignored when full)
//   pop_i             : consume head (ignored when empty)
//   rdata_o           : current head entry
//   count_o           : number of stored entries
//   full_o, empty_o   : registered occupancy flags
module sonic_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push_c, do_pop_c;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointer/count; simultaneous push and pop leave the count unchanged.
    always_comb begin
        do_push_c = push_i && !full_q;
        do_pop_c  = pop_i && !empty_q;
        wr_ptr_d  = do_push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset: entries are only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/sonic_tx_st_adapter.sv
// Adapts a zero-ready-latency streaming source to the hard-IP Avalon-ST TX port,
// which honours tx_st_ready0 with a fixed latency of RDY_LAT cycles.
// Ports:
//   clk_in : sole clock (rising edge)
//   rst    : asynchronous active-high reset
//   bus    : sonic_tx_st_adapter_if.master (upstream beats, hard-IP TX, fifo_level, frame_err)
// Parameters: DATA_W, DEPTH (>= RDY_LAT+2), RDY_LAT (1..4).
// Optional build macro SONIC_TX_FRAME_CHECK_EN adds the input framing checker
// driving tx_st_err0 and frame_err; without it both are tied to 0.
module sonic_tx_st_adapter
    import sonic_tx_st_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned RDY_LAT = RDY_LAT_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst,
    sonic_tx_st_adapter_if.master bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned SR_W  = (RDY_LAT > 1) ? RDY_LAT - 1 : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              empty;
        logic              err;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

    logic             accept_c;
    logic             issue_ok_c;
    logic             pop_c;
    logic             err_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    beat_t            wr_beat_c;
    beat_t            head;
    logic             tx_valid_q;
    beat_t            tx_beat_q;

    assign accept_c = bus.in_valid && !fifo_full;

    // Beat as captured into the buffer, with its framing-error tag.
    always_comb begin
        wr_beat_c       = '0;
        wr_beat_c.data  = bus.in_data;
        wr_beat_c.sop   = bus.in_sop;
        wr_beat_c.eop   = bus.in_eop;
        wr_beat_c.empty = bus.in_empty;
        wr_beat_c.err   = err_c;
    end

    sonic_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst),
        .push_i  (accept_c),
        .wdata_i (wr_beat_c),
        .pop_i   (pop_c),
        .rdata_o (head),
        .count_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Ready delay: RDY_LAT-1 flops here plus the output register give RDY_LAT total.
    if (RDY_LAT == 1) begin : g_no_sr
        assign issue_ok_c = bus.tx_st_ready0;
    end else begin : g_sr
        logic [SR_W-1:0] rdy_sr_q;
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                rdy_sr_q <= '0;
            end else begin
                rdy_sr_q <= (rdy_sr_q << 1) | SR_W'(bus.tx_st_ready0);
            end
        end
        assign issue_ok_c = rdy_sr_q[SR_W-1];
    end

    assign pop_c = issue_ok_c && !fifo_empty;

    // Output stage: data holds its last value when nothing is issued.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_beat_q  <= '0;
        end else begin
            tx_valid_q <= pop_c;
            if (pop_c) begin
                tx_beat_q <= head;
            end
        end
    end

`ifdef SONIC_TX_FRAME_CHECK_EN
    frame_state_t state_q, state_d;
    logic         viol_c;
    logic         frame_err_q;

    // Framing state register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing next state; only accepted beats advance it.
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            case (state_q)
                IDLE:    if (bus.in_sop && !bus.in_eop) state_d = IN_PKT;
                IN_PKT:  if (bus.in_eop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Violation: sop inside a packet, or a non-sop beat outside one.
    always_comb begin
        viol_c = 1'b0;
        if (accept_c) begin
            case (state_q)
                IDLE:    viol_c = !bus.in_sop;
                IN_PKT:  viol_c = bus.in_sop;
                default: viol_c = 1'b0;
            endcase
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (viol_c) begin
            frame_err_q <= 1'b1;
        end
    end

    assign err_c         = viol_c;
    assign bus.frame_err = frame_err_q;
`else
    assign err_c         = 1'b0;
    assign bus.frame_err = 1'b0;
`endif

    assign bus.in_ready     = !fifo_full;
    assign bus.fifo_level   = fifo_level;
    assign bus.tx_st_valid0 = tx_valid_q;
    assign bus.tx_st_data0  = tx_beat_q.data;
    assign bus.tx_st_sop0   = tx_beat_q.sop;
    assign bus.tx_st_eop0   = tx_beat_q.eop;
    assign bus.tx_st_empty0 = tx_beat_q.empty;
    assign bus.tx_st_err0   = tx_beat_q.err;

endmodule

// File: tb/tb_sonic_tx_st_adapter.sv
// Self-checking bench for sonic_tx_st_adapter (DATA_W=128, DEPTH=4, RDY_LAT=2).
// Expected beats are queued when the bench sees them accepted and compared as
// they leave on tx_st_*; a monitor also checks the ready-latency rule.
module tb_sonic_tx_st_adapter;
    import sonic_tx_st_pkg::*;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned RDY_LAT = 2;

`ifdef SONIC_TX_FRAME_CHECK_EN
    localparam logic EXP_FE = 1'b1;
`else
    localparam logic EXP_FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int valid_cnt = 0;

    logic     in_pkt = 1'b0;
    logic     rdy_d1 = 1'b0;
    logic     rdy_d2 = 1'b0;
    tx_beat_t sb[$];
    tx_beat_t mon_got;
    tx_beat_t mon_exp;

    sonic_tx_st_adapter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sonic_tx_st_adapter #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RDY_LAT (RDY_LAT)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference framing model; returns the expected err tag of an accepted beat.
    function automatic logic model_err(input logic s, input logic e);
        logic v;
        v = in_pkt ? s : !s;
        if (!in_pkt) begin
            if (s && !e) in_pkt = 1'b1;
        end else if (e) begin
            in_pkt = 1'b0;
        end
`ifdef SONIC_TX_FRAME_CHECK_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Output monitor: ready latency rule and scoreboard comparison.
    always @(negedge clk) begin
        if (rst) begin
            rdy_d1 = 1'b0;
            rdy_d2 = 1'b0;
        end else begin
            if (bus.tx_st_valid0) begin
                valid_cnt++;
                n_checks++;
                if (rdy_d2 !== 1'b1)
                    $display("FAIL ready_latency cyc=%0d: ready two cycles earlier was %b, required 1", cyc, rdy_d2);
                else
                    n_pass++;
                mon_got.data  = bus.tx_st_data0;
                mon_got.sop   = bus.tx_st_sop0;
                mon_got.eop   = bus.tx_st_eop0;
                mon_got.empty = bus.tx_st_empty0;
                mon_got.err   = bus.tx_st_err0;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL beat_unexpected cyc=%0d: got %h, required no beat", cyc, mon_got);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_got !== mon_exp)
                        $display("FAIL beat_data cyc=%0d: got %h, required %h", cyc, mon_got, mon_exp);
                    else
                        n_pass++;
                end
            end
            rdy_d2 = rdy_d1;
            rdy_d1 = bus.tx_st_ready0;
        end
    end

    // Present one beat until accepted (bounded); queues its expected output.
    task automatic drive_beat(input logic [DATA_W-1:0] d, input logic s, input logic e, input logic m);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = s;
        bus.in_eop   = e;
        bus.in_empty = m;
        for (int i = 0; i < 64; i++) begin
            if (bus.in_ready) begin
                sb.push_back('{data: d, sop: s, eop: e, empty: m, err: model_err(s, e)});
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL accept_timeout: in_ready never 1 within 64 cycles, required acceptance");
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_st_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.tx_st_valid0, bus.tx_st_sop0, bus.tx_st_eop0, bus.tx_st_empty0, bus.tx_st_err0, bus.tx_st_data0} !== '0)
            $display("FAIL reset_outputs: tx_st valid/data = %b/%h, required all 0", bus.tx_st_valid0, bus.tx_st_data0);
        else n_pass++;
        n_checks++;
        if (bus.fifo_level !== '0) $display("FAIL reset_level: got %0d, required 0", bus.fifo_level);
        else n_pass++;
        n_checks++;
        if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, required 0", bus.frame_err);
        else n_pass++;
        // Release with ready high and a beat waiting: valid must stay low RDY_LAT cycles.
        rst = 1'b0;
        in_pkt = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        bus.in_sop   = 1'b1;
        bus.in_eop   = 1'b1;
        bus.in_empty = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end else begin
            n_pass++;
            sb.push_back('{data: bus.in_data, sop: 1'b1, eop: 1'b1, empty: 1'b0, err: model_err(1'b1, 1'b1)});
        end
        for (int i = 0; i < int'(RDY_LAT); i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tx_st_valid0 !== 1'b0) $display("FAIL reset_valid_hold cycle %0d: got %b, required 0", i, bus.tx_st_valid0);
            else n_pass++;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        n_checks++;
        if (sb.size() != 0) $display("FAIL reset_drain: %0d beats outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_single_beat();
        int c0;
        int lat;
        logic err_seen;
        bus.tx_st_ready0 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready: got %b, required 1", bus.in_ready);
        else n_pass++;
        c0 = cyc;
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;
        bus.in_sop   = 1'b1;
        bus.in_eop   = 1'b1;
        bus.in_empty = 1'b0;
        sb.push_back('{data: bus.in_data, sop: 1'b1, eop: 1'b1, empty: 1'b0, err: model_err(1'b1, 1'b1)});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        err_seen = 1'bx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.tx_st_valid0) begin
                lat = cyc - c0;
                err_seen = bus.tx_st_err0;
                break;
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (lat != 2) $display("FAIL single_latency: got %0d cycles, required 2", lat);
        else n_pass++;
        n_checks++;
        if (err_seen !== 1'b0) $display("FAIL single_err: got %b, required 0", err_seen);
        else n_pass++;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        n_checks++;
        if (sb.size() != 0) $display("FAIL single_drain: %0d beats outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int acc;
        int vc0;
        logic exp_v;
        bus.tx_st_ready0 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        acc = 0;
        vc0 = valid_cnt;
        for (int r = 0; r < 20; r++) begin
            bus.tx_st_ready0 = (r >= 10);
            if (acc < 6) begin
                bus.in_valid = 1'b1;
                bus.in_data  = {96'hB0B0_0000_0000_0000_0000_0000, 32'(acc)};
                bus.in_sop   = (acc == 0);
                bus.in_eop   = (acc == 5);
                bus.in_empty = (acc == 5);
                if (bus.in_ready) begin
                    sb.push_back('{data: bus.in_data, sop: bus.in_sop, eop: bus.in_eop,
                                   empty: bus.in_empty, err: model_err(bus.in_sop, bus.in_eop)});
                    acc++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            if (r == 9) begin
                n_checks++;
                if (acc != 4) $display("FAIL bp_accepted: got %0d beats, required 4", acc);
                else n_pass++;
                n_checks++;
                if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", bus.in_ready);
                else n_pass++;
                n_checks++;
                if (bus.fifo_level !== 3'd4) $display("FAIL bp_level: got %0d, required 4", bus.fifo_level);
                else n_pass++;
                n_checks++;
                if (valid_cnt != vc0) $display("FAIL bp_no_valid: got %0d valid cycles, required 0", valid_cnt - vc0);
                else n_pass++;
            end
            @(negedge clk);
            exp_v = (r >= 12 && r <= 17);
            n_checks++;
            if (bus.tx_st_valid0 !== exp_v) $display("FAIL bp_valid cycle %0d: got %b, required %b", r, bus.tx_st_valid0, exp_v);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (acc != 6 || sb.size() != 0) $display("FAIL bp_delivered: accepted %0d outstanding %0d, required 6 and 0", acc, sb.size());
        else n_pass++;
    endtask

    task automatic test_frame();
        bus.tx_st_ready0 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        drive_beat(128'hF1, 1'b1, 1'b0, 1'b0);
        drive_beat(128'hF2, 1'b0, 1'b0, 1'b0);
        drive_beat(128'hF3, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.frame_err !== EXP_FE) $display("FAIL frame_err_set: got %b, required %b", bus.frame_err, EXP_FE);
        else n_pass++;
        drive_beat(128'hF4, 1'b0, 1'b1, 1'b1);
        repeat (6) begin @(posedge clk); #1; end
        n_checks++;
        if (bus.frame_err !== EXP_FE) $display("FAIL frame_err_sticky: got %b, required %b", bus.frame_err, EXP_FE);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL frame_drain: %0d beats outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int  sent;
        int  pos;
        int  len;
        int  guard;
        bit  took;
        sent  = 0;
        pos   = 0;
        len   = $urandom_range(1, 4);
        guard = 0;
        bus.in_valid = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            bus.tx_st_ready0 = ($urandom_range(0, 9) < 6);
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.in_sop   = (pos == 0);
                bus.in_eop   = (pos == len - 1);
                bus.in_empty = 1'($urandom_range(0, 1));
            end
            took = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{data: bus.in_data, sop: bus.in_sop, eop: bus.in_eop,
                               empty: bus.in_empty, err: model_err(bus.in_sop, bus.in_eop)});
                took = 1'b1;
                sent++;
                pos++;
                if (pos == len) begin
                    pos = 0;
                    len = $urandom_range(1, 4);
                end
            end
            @(posedge clk); #1;
            if (took) bus.in_valid = 1'b0;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.tx_st_ready0 = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        n_checks++;
        if (sent != 1000) $display("FAIL rand_sent: got %0d beats accepted, required 1000", sent);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL rand_loss: %0d beats outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int vc0;
        bus.tx_st_ready0 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        drive_beat(128'hA1, 1'b1, 1'b0, 1'b0);
        drive_beat(128'hA2, 1'b0, 1'b0, 1'b0);
        drive_beat(128'hA3, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.fifo_level !== 3'd3) $display("FAIL mid_level_before: got %0d, required 3", bus.fifo_level);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.tx_st_valid0, bus.tx_st_sop0, bus.tx_st_eop0, bus.tx_st_empty0, bus.tx_st_err0, bus.tx_st_data0} !== '0)
            $display("FAIL mid_outputs: tx_st valid/data = %b/%h, required all 0", bus.tx_st_valid0, bus.tx_st_data0);
        else n_pass++;
        n_checks++;
        if (bus.fifo_level !== '0 || bus.frame_err !== 1'b0)
            $display("FAIL mid_status: level %0d frame_err %b, required 0 and 0", bus.fifo_level, bus.frame_err);
        else n_pass++;
        sb.delete();
        in_pkt = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        bus.tx_st_ready0 = 1'b1;
        vc0 = valid_cnt;
        repeat (10) begin @(posedge clk); #1; end
        n_checks++;
        if (valid_cnt != vc0) $display("FAIL mid_no_emit: got %0d valid cycles, required 0", valid_cnt - vc0);
        else n_pass++;
        n_checks++;
        if (bus.fifo_level !== '0) $display("FAIL mid_level_after: got %0d, required 0", bus.fifo_level);
        else n_pass++;
        drive_beat(128'hC0DE, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        n_checks++;
        if (sb.size() != 0) $display("FAIL mid_new_beat: %0d beats outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_sop       = 1'b0;
        bus.in_eop       = 1'b0;
        bus.in_empty     = 1'b0;
        bus.tx_st_ready0 = 1'b0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_frame();
        test_random();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sonic_tx_st_adapter.md
SONIC_TX_ST_ADAPTER -- requirements
Module: sonic_tx_st_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning tx_st data width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning beat buffer entries; legal only if DEPTH >= RDY_LAT+2.
REQ-003 SHALL have parameter RDY_LAT, default 2, meaning hard-IP tx_st ready latency in cycles; legal range 1..4.
REQ-004 Port clk_in  in  1  sole clock; all logic on its rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Ports in_data in DATA_W, in_sop in 1, in_eop in 1, in_empty in 1: upstream beat from the streaming application port.
REQ-007 Port in_valid  in  1  upstream beat valid.
REQ-008 Port in_ready  out  1  upstream ready, zero ready latency.
REQ-009 Ports tx_st_data0 out DATA_W, tx_st_sop0 out 1, tx_st_eop0 out 1, tx_st_empty0 out 1, tx_st_err0 out 1, tx_st_valid0 out 1: hard-IP Avalon-ST TX.
REQ-010 Port tx_st_ready0  in  1  hard-IP ready, honoured with latency RDY_LAT.
REQ-011 Port fifo_level  out  $clog2(DEPTH+1)  buffered beat count.
REQ-012 Port frame_err  out  1  sticky framing-violation flag.

Function
REQ-013 Beat SHALL be accepted on an edge where in_valid && in_ready; in_ready SHALL equal (fifo_level < DEPTH), with no same-cycle pass-through when full.
REQ-014 tx_st_valid0 SHALL be high in cycle n only if tx_st_ready0 was high in cycle n-RDY_LAT; delay via an (RDY_LAT-1)-deep shift register feeding a registered output stage.
REQ-015 On an edge where issue is permitted and the FIFO is non-empty, the head beat SHALL be popped into the output registers; otherwise tx_st_valid0 SHALL be low the next cycle, outputs holding their last data.
REQ-016 Every beat driven with tx_st_valid0 high SHALL count as consumed; no replay, no drop, order preserved.
REQ-017 Minimum latency: beat accepted at edge k SHALL appear on tx_st_* no earlier than the cycle after edge k+1.
REQ-018 Simultaneous push and pop SHALL update fifo_level by net zero; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 tx_st_ready0 deassertion SHALL stop issue exactly RDY_LAT cycles later; buffered beats SHALL be retained.
REQ-020 in_empty SHALL be forwarded unchanged; it is meaningful only with eop.

Reset
REQ-021 On rst, the block SHALL clear the FIFO and pointers, zero the ready shift register, and drive all tx_st_* outputs, fifo_level and frame_err to 0.
REQ-022 Immediately after reset, in_ready SHALL be 1, and tx_st_valid0 SHALL stay 0 for at least RDY_LAT cycles.
REQ-023 Reset mid-packet SHALL discard all buffered beats; no partial packet is emitted after release.

Configuration
REQ-024 With SONIC_TX_FRAME_CHECK_EN defined, an input framing FSM SHALL be built with states IDLE and IN_PKT.
REQ-025 FSM transitions: IDLE to IN_PKT on accepted sop without eop; IN_PKT to IDLE on accepted eop; sop with eop in IDLE SHALL stay IDLE.
REQ-026 A violation (sop in IN_PKT, or non-sop beat in IDLE) SHALL set frame_err sticky until reset and set tx_st_err0 on that beat when issued.
REQ-027 Without the macro, tx_st_err0 and frame_err SHALL be constant 0 and no FSM SHALL exist.

Structure
REQ-028 Package sonic_tx_st_pkg SHALL hold typedef tx_beat_t (data, sop, eop, empty, err), enum frame_state_t and default parameter constants.
REQ-029 Buffering SHALL be one sub-module, sonic_sync_fifo (generic width/depth, show-ahead head).

Verification
REQ-030 Bench SHALL run a single-beat packet (sop=eop=1, data 0x...A5) with tx_st_ready0 held 1: beat appears exactly 2 cycles after acceptance, tx_st_err0=0.
REQ-031 Bench SHALL push 6 beats back-to-back with ready held 0: in_ready drops after 4 beats, fifo_level=4, tx_st_valid0 never asserts.
REQ-032 Bench SHALL raise ready at cycle 10 with RDY_LAT=2: first tx_st_valid0 in cycle 12; all 6 beats delivered in order with no gaps.
REQ-033 Bench SHALL toggle tx_st_ready0 randomly for 1000 beats: checker confirms every valid cycle n has ready at n-2, and scoreboard matches with zero loss.
REQ-034 Bench SHALL assert rst after 3 buffered beats of a 5-beat packet: outputs 0 within the reset, fifo_level=0, no beat emitted after release until new input.
REQ-035 Bench SHALL, with SONIC_TX_FRAME_CHECK_EN, send sop, data, then sop again: frame_err=1 sticky, tx_st_err0=1 on the third beat only.
